imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_loader_fsm.sv | 107 ++++++++++
 rtl/imem_loader.sv | 82 ++++++++
 tb/tb_imem_loader.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: loader state encoding
// and the instruction memory size in bytes.
package imem_loader_pkg;

   localparam int IMEM_DEPTH = 512;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_HI = 3'd1,
      LEN_LO = 3'd2,
      DATA   = 3'd3,
      CHK    = 3'd4,
      DONE   = 3'd5,
      ERROR  = 3'd6
   } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory byte write port of the loader.
// master = loader side, slave = byte source / memory side.
interface imem_loader_if
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = $clog2(IMEM_DEPTH)
);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;

   modport master (
      input  rx_data, rx_valid,
      output rx_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output rx_data, rx_valid,
      input  rx_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_loader_fsm.sv
// Loader control: state register, 16-bit byte counter and length register.
// Optional macro IMEM_LOADER_CHECKSUM_EN routes the end of the image through CHK.
module imem_loader_fsm
   import imem_loader_pkg::*;
#(
   parameter int DEPTH  = IMEM_DEPTH,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic              chk_ok,
   output logic              rx_ready,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              cpu_hold,
   output logic              data_xfer,
   output logic [ADDR_W-1:0] wr_addr
);

   localparam logic [16:0] DEPTH_17 = 17'(DEPTH);
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t END_ST = CHK;
`else
   localparam state_t END_ST = DONE;
`endif

   state_t      state, state_nxt;
   logic [15:0] counter;
   logic [15:0] len;
   logic [7:0]  len_hi;
   logic        xfer;
   logic [15:0] len_rx;
   logic        len_bad;
   logic        last_byte;

   assign xfer      = rx_valid && rx_ready;
   assign len_rx    = {len_hi, rx_data};
   assign len_bad   = ({1'b0, len_rx} > DEPTH_17) || (len_rx[1:0] != 2'b00);
   assign last_byte = (counter == len - 16'd1);
   assign data_xfer = (state == DATA) && xfer;
   assign wr_addr   = counter[ADDR_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         counter <= '0;
         len     <= '0;
         len_hi  <= '0;
      end else begin
         state <= state_nxt;
         if (state == LEN_HI && xfer)
            len_hi <= rx_data;
         if (state == LEN_LO && xfer) begin
            len     <= len_rx;
            counter <= '0;
         end
         if (data_xfer)
            counter <= counter + 16'd1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE, ERROR: if (start) state_nxt = LEN_HI;
         LEN_HI:            if (xfer) state_nxt = LEN_LO;
         LEN_LO: begin
            if (xfer) begin
               if (len_bad)
                  state_nxt = ERROR;
               else if (len_rx == 16'd0)
                  state_nxt = END_ST;
               else
                  state_nxt = DATA;
            end
         end
         DATA:              if (xfer && last_byte) state_nxt = END_ST;
         CHK:               if (xfer) state_nxt = chk_ok ? DONE : ERROR;
         default:           state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rx_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      cpu_hold = 1'b1;
      case (state)
         LEN_HI, LEN_LO, DATA, CHK: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
         end
         DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
         end
         ERROR:   err = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader for the byte-addressed instruction memory.
// Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH  = IMEM_DEPTH,
   parameter int ADDR_W = 9
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   imem_loader_if.master bus,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          cpu_hold
);

   logic              data_xfer;
   logic              chk_ok;
   logic [ADDR_W-1:0] wr_addr;
   logic              we_p1;
   logic [ADDR_W-1:0] addr_p1;
   logic [7:0]        wdata_p1;

   imem_loader_fsm #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .rx_data   (bus.rx_data),
      .rx_valid  (bus.rx_valid),
      .chk_ok    (chk_ok),
      .rx_ready  (bus.rx_ready),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .cpu_hold  (cpu_hold),
      .data_xfer (data_xfer),
      .wr_addr   (wr_addr)
   );

   // p0 -> p1: accepted data byte becomes a one-cycle write on the next cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_p1    <= 1'b0;
         addr_p1  <= '0;
         wdata_p1 <= '0;
      end else begin
         we_p1 <= data_xfer;
         if (data_xfer) begin
            addr_p1  <= wr_addr;
            wdata_p1 <= bus.rx_data;
         end
      end
   end

   assign bus.mem_we    = we_p1;
   assign bus.mem_addr  = addr_p1;
   assign bus.mem_wdata = wdata_p1;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] xor_acc;

   // Cleared by an honoured start so each image is checked on its own bytes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         xor_acc <= '0;
      else if (start && !busy)
         xor_acc <= '0;
      else if (data_xfer)
         xor_acc <= xor_acc ^ bus.rx_data;
   end

   assign chk_ok = (bus.rx_data == xor_acc);
`else
   assign chk_ok = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (default build; checksum
// byte appended automatically when IMEM_LOADER_CHECKSUM_EN is defined).
module tb_imem_loader;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic busy, done, err, cpu_hold;

   imem_loader_if #(.ADDR_W(9)) bus ();

   imem_loader #(.DEPTH(512), .ADDR_W(9)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .bus      (bus),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .cpu_hold (cpu_hold)
   );

   always #5 clk = ~clk;

   logic [7:0] tmem [0:511];
   int         wcount = 0;

   always @(posedge clk) begin
      if (bus.mem_we) begin
         tmem[bus.mem_addr] <= bus.mem_wdata;
         wcount <= wcount + 1;
      end
   end

   int         n_cmp = 0;
   int         n_bad = 0;
   int         w0;
   logic [7:0] img[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] fetch(input int pc);
      return {tmem[pc], tmem[pc+1], tmem[pc+2], tmem[pc+3]};
   endfunction

   task automatic add_chk();
`ifdef IMEM_LOADER_CHECKSUM_EN
      logic [7:0] x;
      x = 8'h00;
      for (int i = 2; i < img.size(); i++) x = x ^ img[i];
      img.push_back(x);
`endif
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // Sends img; each data byte must appear on the write port one cycle after acceptance.
   task automatic send_image(input int gapmax, input bit poke);
      int len;
      int gap;
      int n;
      len = int'({img[0], img[1]});
      for (int i = 0; i < img.size(); i++) begin
         gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
         if (poke && i == 4 && gap < 2) gap = 2;
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            start = (poke && i == 4 && g == 0);
         end
         @(negedge clk);
         start = 1'b0;
         bus.rx_valid = 1'b1;
         bus.rx_data = img[i];
         n = 0;
         while (!bus.rx_ready && n < 50) begin
            @(negedge clk);
            n++;
         end
         check_eq("rdy_wait", bus.rx_ready, 1);
         @(posedge clk);
         #1;
         if (i >= 2 && i - 2 < len) begin
            check_eq("wr_we", bus.mem_we, 1);
            check_eq("wr_addr", bus.mem_addr, i - 2);
            check_eq("wr_data", bus.mem_wdata, img[i]);
         end else begin
            check_eq("hdr_no_we", bus.mem_we, 0);
         end
      end
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic check_done_now(input string tag, input logic exp_we);
      check_eq({tag, "_we"}, bus.mem_we, exp_we);
      check_eq({tag, "_done"}, done, 1);
      check_eq({tag, "_err"}, err, 0);
      check_eq({tag, "_hold"}, cpu_hold, 0);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_rdy"}, bus.rx_ready, 0);
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_rdy"}, bus.rx_ready, 0);
      check_eq({tag, "_we"}, bus.mem_we, 0);
      check_eq({tag, "_addr"}, bus.mem_addr, 0);
      check_eq({tag, "_wdata"}, bus.mem_wdata, 0);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_done"}, done, 0);
      check_eq({tag, "_err"}, err, 0);
      check_eq({tag, "_hold"}, cpu_hold, 1);
   endtask

   task automatic bad_len(input string tag, input logic [7:0] hi, input logic [7:0] lo);
      pulse_start();
      check_eq({tag, "_start_err_clr"}, err, 0);
      w0 = wcount;
      img = '{hi, lo};
      send_image(0, 1'b0);
      check_eq({tag, "_err"}, err, 1);
      check_eq({tag, "_done"}, done, 0);
      check_eq({tag, "_hold"}, cpu_hold, 1);
      check_eq({tag, "_busy"}, busy, 0);
      @(negedge clk);
      check_eq({tag, "_nwr"}, wcount - w0, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (2) @(negedge clk);
      check_reset_vals("rst");
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("idle_busy", busy, 0);

      // Basic 8-byte image
      pulse_start();
      check_eq("t1_busy", busy, 1);
      check_eq("t1_hold", cpu_hold, 1);
      check_eq("t1_rdy", bus.rx_ready, 1);
      w0 = wcount;
      img = '{8'h00, 8'h08, 8'h00, 8'h10, 8'h04, 8'h13, 8'h00, 8'h20, 8'h04, 8'h93};
      add_chk();
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_image(0, 1'b0);
      check_done_now("t1_end", 1'b0);
`else
      send_image(0, 1'b0);
      check_done_now("t1_end", 1'b1);
`endif
      @(negedge clk);
      check_eq("t1_we_pulse", bus.mem_we, 0);
      check_eq("t1_nwr", wcount - w0, 8);
      check_eq("t1_pc0", fetch(0), 32'h00100413);
      check_eq("t1_pc4", fetch(4), 32'h00200493);

      // Bytes offered while not ready are not consumed
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'hFF;
      repeat (3) @(negedge clk);
      check_eq("bp_done", done, 1);
      check_eq("bp_nwr", wcount - w0, 8);
      bus.rx_valid = 1'b0;

      // Zero-length image
      pulse_start();
      check_eq("z_done_clr", done, 0);
      w0 = wcount;
      img = '{8'h00, 8'h00};
      add_chk();
      send_image(0, 1'b0);
      check_done_now("z_end", 1'b0);
      @(negedge clk);
      check_eq("z_nwr", wcount - w0, 0);

      // Rejected lengths
      bad_len("odd", 8'h00, 8'h06);
      bad_len("big", 8'h02, 8'h04);

      // Gapped stream with an ignored start mid-load
      pulse_start();
      check_eq("g_err_clr", err, 0);
      check_eq("g_busy", busy, 1);
      w0 = wcount;
      img = '{8'h00, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      add_chk();
      send_image(3, 1'b1);
      check_eq("g_done", done, 1);
      check_eq("g_hold", cpu_hold, 0);
      @(negedge clk);
      check_eq("g_nwr", wcount - w0, 8);
      check_eq("g_pc0", fetch(0), 32'h11223344);
      check_eq("g_pc4", fetch(4), 32'h55667788);

      // Reset after three data bytes, then a full reload
      pulse_start();
      img = '{8'h00, 8'h08, 8'h00, 8'h10, 8'h04};
      send_image(0, 1'b0);
      check_eq("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check_reset_vals("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      pulse_start();
      w0 = wcount;
      img = '{8'h00, 8'h08, 8'h00, 8'h10, 8'h04, 8'h13, 8'h00, 8'h20, 8'h04, 8'h93};
      add_chk();
      send_image(0, 1'b0);
      check_eq("rl_done", done, 1);
      check_eq("rl_hold", cpu_hold, 0);
      @(negedge clk);
      check_eq("rl_nwr", wcount - w0, 8);
      check_eq("rl_pc0", fetch(0), 32'h00100413);
      check_eq("rl_pc4", fetch(4), 32'h00200493);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // AA^BB^CC^DD == 00
      pulse_start();
      w0 = wcount;
      img = '{8'h00, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
      send_image(0, 1'b0);
      check_eq("ck_ok_done", done, 1);
      check_eq("ck_ok_err", err, 0);
      pulse_start();
      img = '{8'h00, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
      send_image(0, 1'b0);
      check_eq("ck_bad_err", err, 1);
      check_eq("ck_bad_hold", cpu_hold, 1);
      @(negedge clk);
      check_eq("ck_nwr", wcount - w0, 8);
      check_eq("ck_pc0", fetch(0), 32'hAABBCCDD);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
